// File: rtl/psum_fifo_pkg.sv
// Shared definitions for the psum FIFO drain: tag layout, FSM states
// and FIFO entry sizing.
package psum_fifo_pkg;

    localparam int TAG_W        = 8;
    localparam int TAG_LAST_BIT = 7;
    localparam int TAG_ROW_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        CAPT,
        EMIT
    } state_e;

    // Column field sits directly above the row field.
    function automatic int tag_col_lsb(input int n_rows);
        return TAG_ROW_LSB + $clog2(n_rows);
    endfunction

    function automatic int entry_w(input int psum_w);
        return psum_w + TAG_W;
    endfunction

endpackage

// File: rtl/psum_acc_buf.sv
// pr x col signed psum accumulator with one read-modify-write port,
// a synchronous clear-all and a combinational row read port.
module psum_acc_buf
    import psum_fifo_pkg::*;
#(
    parameter int col     = 8,
    parameter int pr      = 8,
    parameter int bw_psum = 12,
    localparam int RW     = $clog2(pr),
    localparam int CW     = $clog2(col)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      we,
    input  logic [RW-1:0]             wr_row,
    input  logic [CW-1:0]             wr_col,
    input  logic signed [bw_psum-1:0] addend,
    input  logic [RW-1:0]             rd_row,
    output logic [col*bw_psum-1:0]    rd_data
);

    logic signed [bw_psum-1:0] acc_q [pr][col];
    logic signed [bw_psum-1:0] acc_d [pr][col];

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            for (int r = 0; r < pr; r++) begin
                for (int c = 0; c < col; c++) begin
                    acc_d[r][c] = '0;
                end
            end
        end else if (we) begin
            // Wraps modulo 2^bw_psum by construction.
            acc_d[wr_row][wr_col] = acc_q[wr_row][wr_col] + addend;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < pr; r++) begin
                for (int c = 0; c < col; c++) begin
                    acc_q[r][c] <= '0;
                end
            end
        end else begin
            acc_q <= acc_d;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int c = 0; c < col; c++) begin
            rd_data[c*bw_psum +: bw_psum] = acc_q[rd_row][c];
        end
    end

endmodule

// File: rtl/psum_fifo_drain.sv
// Read-side consumer of the psum async FIFO: pops tagged psums, merges
// them into the accumulator, then streams rows out over valid/ready.
module psum_fifo_drain
    import psum_fifo_pkg::*;
#(
    parameter int col     = 8,
    parameter int bw      = 4,
    parameter int bw_psum = 2*bw+4,
    parameter int pr      = 8,
    localparam int RW     = $clog2(pr),
    localparam int CW     = $clog2(col),
    localparam int EW     = entry_w(bw_psum)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   fifo_empty,
    input  logic [EW-1:0]          fifo_rd_data,
    output logic                   fifo_rd_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [col*bw_psum-1:0] out_data,
    output logic [RW-1:0]          out_row,
    output logic                   busy,
    output logic                   done
);

    localparam int COL_LSB = tag_col_lsb(pr);

    state_e        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic          done_q, done_d;

    logic                      clr, we;
    logic [RW-1:0]             tag_row;
    logic [CW-1:0]             tag_col;
    logic                      tag_last;
    logic signed [bw_psum-1:0] psum;
    logic [col*bw_psum-1:0]    rd_data;
    logic                      tag_unused;

    assign tag_row    = fifo_rd_data[TAG_ROW_LSB +: RW];
    assign tag_col    = fifo_rd_data[COL_LSB +: CW];
    assign tag_last   = fifo_rd_data[TAG_LAST_BIT];
    assign psum       = fifo_rd_data[EW-1:TAG_W];
    assign tag_unused = ^fifo_rd_data;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        done_d  = 1'b0;
        clr     = 1'b0;
        we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    state_d = POP;
                end
            end
            POP: begin
                if (!fifo_empty) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                we = 1'b1;
                if (tag_last) begin
                    state_d = EMIT;
                    row_d   = '0;
                end else begin
                    state_d = POP;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (row_q == RW'(pr-1)) begin
                        state_d = IDLE;
                        row_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    psum_acc_buf #(
        .col    (col),
        .pr     (pr),
        .bw_psum(bw_psum)
    ) u_buf (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .we     (we),
        .wr_row (tag_row),
        .wr_col (tag_col),
        .addend (psum),
        .rd_row (row_q),
        .rd_data(rd_data)
    );

    // Only one pop outstanding: the request exists only in POP.
    assign fifo_rd_en = (state_q == POP) && !fifo_empty;
    assign out_valid  = (state_q == EMIT);
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign out_row    = row_q;
    assign out_data   = out_valid ? rd_data : '0;

endmodule

// File: tb/tb_psum_fifo_drain.sv
// Self-checking bench for psum_fifo_drain with a queue-based FIFO model
// and an integer-arithmetic accumulator reference.
module tb_psum_fifo_drain;

    localparam int COL = 8;
    localparam int BW  = 4;
    localparam int BWP = 2*BW+4;
    localparam int PR  = 8;
    localparam int EW  = BWP + 8;
    localparam int DW  = COL*BWP;

    logic          clk;
    logic          reset;
    logic          start;
    logic          fifo_empty;
    logic [EW-1:0] fifo_rd_data;
    logic          fifo_rd_en;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [2:0]    out_row;
    logic          busy;
    logic          done;

    psum_fifo_drain #(
        .col    (COL),
        .bw     (BW),
        .bw_psum(BWP),
        .pr     (PR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .fifo_empty  (fifo_empty),
        .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en  (fifo_rd_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_row     (out_row),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [EW-1:0] fq [$];
    bit            stall;
    bit            rnd_empty;
    int            pops;
    int            exp_acc [PR][COL];

    logic [DW-1:0] obs_row [PR];
    int            hs_cnt [PR];
    int            done_cnt, done_busy, done_early;
    int            stall_err, order_err;
    int            first_valid, first_hs, last_hs;
    bit            timed_out;

    int n_cmp;
    int n_fail;

    function automatic int wrap(input int x);
        int v;
        v = x % 4096;
        if (v < 0) v += 4096;
        if (v >= 2048) v -= 4096;
        return v;
    endfunction

    function automatic logic [DW-1:0] exp_row(input int r);
        logic [DW-1:0] v;
        logic [31:0]   t;
        v = '0;
        for (int c = 0; c < COL; c++) begin
            t = exp_acc[r][c];
            v[c*BWP +: BWP] = t[BWP-1:0];
        end
        return v;
    endfunction

    task automatic clear_model();
        for (int r = 0; r < PR; r++)
            for (int c = 0; c < COL; c++)
                exp_acc[r][c] = 0;
    endtask

    task automatic model_add(input int r, input int c, input int p);
        exp_acc[r][c] = wrap(exp_acc[r][c] + p);
    endtask

    task automatic push_entry(input int r, input int c, input int p,
                              input bit last, input bit mdl);
        logic [7:0]     tag;
        logic [BWP-1:0] pv;
        logic [31:0]    rr, cc, pp;
        rr = r;
        cc = c;
        pp = p;
        tag = '0;
        tag[2:0] = rr[2:0];
        tag[5:3] = cc[2:0];
        tag[6] = 1'($urandom_range(0, 1));
        tag[7] = last;
        pv = pp[BWP-1:0];
        fq.push_back({pv, tag});
        fifo_empty = stall || (fq.size() == 0);
        if (mdl) model_add(r, c, p);
    endtask

    task automatic rand_frame(input int n);
        int r, c, p;
        for (int k = 0; k < n; k++) begin
            r = int'($urandom_range(0, PR-1));
            c = int'($urandom_range(0, COL-1));
            p = int'($urandom_range(0, 4095)) - 2048;
            push_entry(r, c, p, k == n-1, 1'b1);
        end
    endtask

    // One clock: FIFO pops on the edge where fifo_rd_en was high.
    task automatic step();
        bit pop;
        @(negedge clk);
        pop = fifo_rd_en;
        @(posedge clk);
        #1;
        if (pop && fq.size() > 0) begin
            fifo_rd_data = fq.pop_front();
            pops++;
        end
        if (rnd_empty) stall = ($urandom_range(0, 3) == 0);
        fifo_empty = stall || (fq.size() == 0);
        #1;
    endtask

    task automatic start_frame();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic collect_frame(input int mode);
        logic [DW-1:0] held_d;
        logic [2:0]    held_r;
        bit            held;
        bit            got;
        int            nxt;
        held = 0;
        got = 0;
        nxt = 0;
        held_d = '0;
        held_r = '0;
        for (int r = 0; r < PR; r++) begin
            hs_cnt[r] = 0;
            obs_row[r] = '0;
        end
        done_cnt = 0;
        done_busy = 1;
        done_early = 0;
        stall_err = 0;
        order_err = 0;
        first_valid = -1;
        first_hs = -1;
        last_hs = -1;
        for (int i = 0; i < 500; i++) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (i % 2) == 1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (held && out_valid &&
                (out_data !== held_d || out_row !== held_r))
                stall_err++;
            held = 0;
            if (done) begin
                done_cnt++;
                done_busy = busy;
                if (nxt != PR) done_early++;
                got = 1;
                break;
            end
            if (out_valid && first_valid < 0) first_valid = i;
            if (out_valid && out_ready) begin
                if (int'(out_row) != nxt) order_err++;
                obs_row[out_row] = out_data;
                hs_cnt[out_row]++;
                if (nxt == 0) first_hs = i;
                last_hs = i;
                nxt++;
            end else if (out_valid) begin
                held = 1;
                held_d = out_data;
                held_r = out_row;
            end
            step();
        end
        timed_out = !got;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        n_cmp++;
        if (fifo_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rd_en got %b want 0", fifo_rd_en);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got %b want 0", out_valid);
        end
        n_cmp++;
        if (out_row !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_row got %0d want 0", out_row);
        end
        n_cmp++;
        if (out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data got %h want 0", out_data);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done got %b want 0", done);
        end
    endtask

    task automatic test_basic();
        int bad, extra;
        clear_model();
        push_entry(0, 0, 5, 1'b0, 1'b1);
        push_entry(0, 0, -2, 1'b0, 1'b1);
        push_entry(7, 7, 100, 1'b1, 1'b1);
        start_frame();
        n_cmp++;
        if (busy !== 1'b1 || fifo_rd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_start got busy=%b rd_en=%b want 1 1",
                     busy, fifo_rd_en);
        end
        collect_frame(0);
        n_cmp++;
        if (timed_out) begin
            n_fail++;
            $display("FAIL basic_timeout got no done want done");
        end
        n_cmp++;
        if (obs_row[0][BWP-1:0] !== 12'd3) begin
            n_fail++;
            $display("FAIL basic_r0c0 got %h want 003", obs_row[0][BWP-1:0]);
        end
        n_cmp++;
        if (obs_row[7][DW-1 -: BWP] !== 12'd100) begin
            n_fail++;
            $display("FAIL basic_r7c7 got %h want 064",
                     obs_row[7][DW-1 -: BWP]);
        end
        for (int r = 0; r < PR; r++) begin
            n_cmp++;
            if (obs_row[r] !== exp_row(r)) begin
                n_fail++;
                $display("FAIL basic_row%0d got %h want %h",
                         r, obs_row[r], exp_row(r));
            end
        end
        n_cmp++;
        if (first_valid != 6) begin
            n_fail++;
            $display("FAIL basic_latency got %0d want 6", first_valid);
        end
        n_cmp++;
        if (last_hs - first_hs != PR-1) begin
            n_fail++;
            $display("FAIL basic_row_span got %0d want %0d",
                     last_hs - first_hs, PR-1);
        end
        bad = 0;
        for (int r = 0; r < PR; r++) if (hs_cnt[r] != 1) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL basic_once got %0d bad rows want 0", bad);
        end
        n_cmp++;
        if (done_busy != 0) begin
            n_fail++;
            $display("FAIL basic_done_busy got %0d want 0", done_busy);
        end
        extra = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (done) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL basic_done_pulse got %0d extra want 0", extra);
        end
    endtask

    task automatic test_wrap();
        clear_model();
        push_entry(0, 0, 2047, 1'b0, 1'b1);
        push_entry(0, 0, 1, 1'b0, 1'b1);
        push_entry(1, 1, -2048, 1'b0, 1'b1);
        push_entry(1, 1, -1, 1'b1, 1'b1);
        start_frame();
        collect_frame(2);
        n_cmp++;
        if (timed_out) begin
            n_fail++;
            $display("FAIL wrap_timeout got no done want done");
        end
        n_cmp++;
        if (obs_row[0][BWP-1:0] !== 12'h800) begin
            n_fail++;
            $display("FAIL wrap_pos got %h want 800", obs_row[0][BWP-1:0]);
        end
        n_cmp++;
        if (obs_row[1][2*BWP-1 -: BWP] !== 12'h7ff) begin
            n_fail++;
            $display("FAIL wrap_neg got %h want 7ff",
                     obs_row[1][2*BWP-1 -: BWP]);
        end
        for (int r = 0; r < PR; r++) begin
            n_cmp++;
            if (obs_row[r] !== exp_row(r)) begin
                n_fail++;
                $display("FAIL wrap_row%0d got %h want %h",
                         r, obs_row[r], exp_row(r));
            end
        end
    endtask

    task automatic test_empty_stall();
        int p0;
        clear_model();
        stall = 1'b1;
        fifo_empty = 1'b1;
        p0 = pops;
        start_frame();
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (busy !== 1'b1 || fifo_rd_en !== 1'b0 || out_valid !== 1'b0)
            begin
                n_fail++;
                $display("FAIL stall_cyc%0d got busy=%b rd_en=%b vld=%b want 1 0 0",
                         k, busy, fifo_rd_en, out_valid);
            end
            step();
        end
        n_cmp++;
        if (pops != p0) begin
            n_fail++;
            $display("FAIL stall_pops got %0d want 0", pops - p0);
        end
        rand_frame(5);
        stall = 1'b0;
        fifo_empty = (fq.size() == 0);
        collect_frame(0);
        n_cmp++;
        if (timed_out) begin
            n_fail++;
            $display("FAIL stall_timeout got no done want done");
        end
        for (int r = 0; r < PR; r++) begin
            n_cmp++;
            if (obs_row[r] !== exp_row(r)) begin
                n_fail++;
                $display("FAIL stall_row%0d got %h want %h",
                         r, obs_row[r], exp_row(r));
            end
        end
    endtask

    task automatic test_backpressure();
        int bad;
        clear_model();
        rand_frame(6);
        start_frame();
        collect_frame(1);
        n_cmp++;
        if (timed_out) begin
            n_fail++;
            $display("FAIL bp_timeout got no done want done");
        end
        n_cmp++;
        if (stall_err != 0) begin
            n_fail++;
            $display("FAIL bp_stable got %0d changes want 0", stall_err);
        end
        n_cmp++;
        if (order_err != 0) begin
            n_fail++;
            $display("FAIL bp_order got %0d errors want 0", order_err);
        end
        bad = 0;
        for (int r = 0; r < PR; r++) if (hs_cnt[r] != 1) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_once got %0d bad rows want 0", bad);
        end
        n_cmp++;
        if (done_early != 0 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL bp_done got early=%0d cnt=%0d want 0 1",
                     done_early, done_cnt);
        end
        for (int r = 0; r < PR; r++) begin
            n_cmp++;
            if (obs_row[r] !== exp_row(r)) begin
                n_fail++;
                $display("FAIL bp_row%0d got %h want %h",
                         r, obs_row[r], exp_row(r));
            end
        end
    endtask

    task automatic test_frame_boundary();
        int p0;
        clear_model();
        push_entry(3, 2, 10, 1'b0, 1'b1);
        push_entry(3, 2, -4, 1'b1, 1'b1);
        push_entry(3, 2, 7, 1'b0, 1'b0);
        push_entry(0, 5, -9, 1'b0, 1'b0);
        push_entry(6, 1, 33, 1'b1, 1'b0);
        p0 = pops;
        start_frame();
        collect_frame(0);
        n_cmp++;
        if (pops - p0 != 2 || fq.size() != 3) begin
            n_fail++;
            $display("FAIL fb_pops got pops=%0d left=%0d want 2 3",
                     pops - p0, fq.size());
        end
        for (int r = 0; r < PR; r++) begin
            n_cmp++;
            if (obs_row[r] !== exp_row(r)) begin
                n_fail++;
                $display("FAIL fbA_row%0d got %h want %h",
                         r, obs_row[r], exp_row(r));
            end
        end
        clear_model();
        model_add(3, 2, 7);
        model_add(0, 5, -9);
        model_add(6, 1, 33);
        start_frame();
        collect_frame(2);
        n_cmp++;
        if (timed_out || pops - p0 != 5) begin
            n_fail++;
            $display("FAIL fbB_pops got pops=%0d to=%0d want 5 0",
                     pops - p0, timed_out);
        end
        for (int r = 0; r < PR; r++) begin
            n_cmp++;
            if (obs_row[r] !== exp_row(r)) begin
                n_fail++;
                $display("FAIL fbB_row%0d got %h want %h",
                         r, obs_row[r], exp_row(r));
            end
        end
    endtask

    task automatic test_reset_mid();
        int p0, busy_seen;
        clear_model();
        push_entry(0, 0, 5, 1'b0, 1'b0);
        push_entry(2, 3, 7, 1'b0, 1'b1);
        p0 = pops;
        start_frame();
        for (int k = 0; k < 20; k++) begin
            if (pops != p0) break;
            step();
        end
        n_cmp++;
        if (pops == p0) begin
            n_fail++;
            $display("FAIL rst_pop got 0 pops want 1");
        end
        reset = 1'b1;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        n_cmp++;
        if ({fifo_rd_en, out_valid, busy, done} !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_ctl got %b want 0000",
                     {fifo_rd_en, out_valid, busy, done});
        end
        n_cmp++;
        if (out_row !== 3'd0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL rst_out got row=%0d data=%h want 0 0",
                     out_row, out_data);
        end
        busy_seen = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (busy) busy_seen++;
        end
        n_cmp++;
        if (busy_seen != 0) begin
            n_fail++;
            $display("FAIL rst_start_ignored got %0d busy cycles want 0",
                     busy_seen);
        end
        push_entry(5, 5, 1, 1'b1, 1'b1);
        start_frame();
        collect_frame(0);
        n_cmp++;
        if (timed_out) begin
            n_fail++;
            $display("FAIL rst_timeout got no done want done");
        end
        for (int r = 0; r < PR; r++) begin
            n_cmp++;
            if (obs_row[r] !== exp_row(r)) begin
                n_fail++;
                $display("FAIL rst_row%0d got %h want %h",
                         r, obs_row[r], exp_row(r));
            end
        end
    endtask

    task automatic test_random();
        rnd_empty = 1'b1;
        for (int f = 0; f < 20; f++) begin
            clear_model();
            rand_frame(int'($urandom_range(1, 12)));
            start_frame();
            collect_frame(2);
            n_cmp++;
            if (timed_out || done_cnt != 1) begin
                n_fail++;
                $display("FAIL rnd%0d_done got to=%0d cnt=%0d want 0 1",
                         f, timed_out, done_cnt);
            end
            for (int r = 0; r < PR; r++) begin
                n_cmp++;
                if (obs_row[r] !== exp_row(r)) begin
                    n_fail++;
                    $display("FAIL rnd%0d_row%0d got %h want %h",
                             f, r, obs_row[r], exp_row(r));
                end
            end
        end
        rnd_empty = 1'b0;
        stall = 1'b0;
        fifo_empty = (fq.size() == 0);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        pops = 0;
        stall = 1'b0;
        rnd_empty = 1'b0;
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        fifo_empty = 1'b1;
        fifo_rd_data = '0;
        clear_model();
        test_reset();
        test_basic();
        test_wrap();
        test_empty_stall();
        test_backpressure();
        test_frame_boundary();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
